// File: rtl/hs_pkg.sv
// Shared definitions for the handshake (valid/ready) datapath stages.
package hs_pkg;

  localparam int unsigned BYTE_W = 8;

  // Ceiling log2, never below 1 so that a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // One keep bit per byte lane.
  function automatic int unsigned keep_width(input int unsigned bytes);
    return bytes;
  endfunction

endpackage

// File: rtl/hs_byte_packer_if.sv
// Byte-in / word-out valid/ready bus of the byte packer.
interface hs_byte_packer_if #(parameter int unsigned BYTES = 4);
  import hs_pkg::*;

  localparam int unsigned WORD_W = BYTE_W * BYTES;
  localparam int unsigned KEEP_W = keep_width(BYTES);

  logic              valid_pre_i;
  logic [BYTE_W-1:0] data_pre_i;
  logic              last_pre_i;
  logic              ready_pre_o;
  logic              valid_post_o;
  logic [WORD_W-1:0] data_post_o;
  logic [KEEP_W-1:0] keep_post_o;
  logic              last_post_o;
  logic              ready_post_i;

  // Packer side.
  modport slave (
    input  valid_pre_i, data_pre_i, last_pre_i, ready_post_i,
    output ready_pre_o, valid_post_o, data_post_o, keep_post_o, last_post_o
  );

  // Upstream source / downstream sink side.
  modport master (
    output valid_pre_i, data_pre_i, last_pre_i, ready_post_i,
    input  ready_pre_o, valid_post_o, data_post_o, keep_post_o, last_post_o
  );

endinterface

// File: rtl/hs_out_slot.sv
// Single-entry valid/ready holding register; holds its payload stable until transferred.
module hs_out_slot #(
  parameter int unsigned W  = 32,
  parameter int unsigned KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  ld_data,
  input  logic [KW-1:0] ld_keep,
  input  logic          ld_last,
  input  logic          ready,
  output logic          valid,
  output logic [W-1:0]  data,
  output logic [KW-1:0] keep,
  output logic          last,
  output logic          slot_free_c
);

  assign slot_free_c = !valid || ready;

  // Load wins over transfer: a same-cycle load replaces the word leaving the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      keep  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= ld_data;
      keep  <= ld_keep;
      last  <= ld_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hs_byte_packer.sv
// Packs BYTES consecutive bytes (first byte in lane 0) into one word with a lane-keep mask.
module hs_byte_packer
  import hs_pkg::*;
#(
  parameter int unsigned BYTES = 4
) (
  input  logic             clk,
  input  logic             rst,
  hs_byte_packer_if.slave  bus
);

  localparam int unsigned WORD_W    = BYTE_W * BYTES;
  localparam int unsigned KEEP_W    = keep_width(BYTES);
  localparam int unsigned CNT_W     = clog2(BYTES);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BYTES - 1);

  logic [WORD_W-1:0] acc_data, ins_data, ld_data;
  logic [KEEP_W-1:0] acc_keep, ins_keep, ld_keep;
  logic [CNT_W-1:0]  cnt;
  logic              close_pending;
  logic              slot_free, cnt_last, accept, pend_move, close_now, load, ld_last;

  assign cnt_last        = (cnt == LAST_LANE);
  assign bus.ready_pre_o = !rst && !close_pending && (slot_free || !cnt_last);
  assign accept          = bus.valid_pre_i && bus.ready_pre_o;
  assign pend_move       = close_pending && slot_free;
  assign close_now       = accept && (cnt_last || (bus.last_pre_i && slot_free));
  assign load            = pend_move || close_now;

  // Accumulator with the incoming byte merged into lane cnt.
  always_comb begin
    ins_data = acc_data;
    ins_keep = acc_keep;
    for (int k = 0; k < BYTES; k++) begin
      if (cnt == CNT_W'(k)) begin
        ins_data[k*BYTE_W +: BYTE_W] = bus.data_pre_i;
        ins_keep[k]                  = 1'b1;
      end
    end
    ld_data = close_pending ? acc_data : ins_data;
    ld_keep = close_pending ? acc_keep : ins_keep;
    ld_last = close_pending ? 1'b1     : bus.last_pre_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_data      <= '0;
      acc_keep      <= '0;
      cnt           <= '0;
      close_pending <= 1'b0;
    end else if (pend_move || close_now) begin
      acc_data      <= '0;
      acc_keep      <= '0;
      cnt           <= '0;
      close_pending <= 1'b0;
    end else if (accept) begin
      // A last byte that cannot reach the slot yet waits here as a pending close.
      acc_data      <= ins_data;
      acc_keep      <= ins_keep;
      cnt           <= cnt + CNT_W'(1);
      close_pending <= bus.last_pre_i;
    end
  end

  hs_out_slot #(
    .W  (WORD_W),
    .KW (KEEP_W)
  ) u_out_slot (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .ld_data     (ld_data),
    .ld_keep     (ld_keep),
    .ld_last     (ld_last),
    .ready       (bus.ready_post_i),
    .valid       (bus.valid_post_o),
    .data        (bus.data_post_o),
    .keep        (bus.keep_post_o),
    .last        (bus.last_post_o),
    .slot_free_c (slot_free)
  );

endmodule
